// File: rtl/bank_window_fetch.sv
// Streams a sample segment out of one feature-memory bank and hands sliding
// KERNEL-sample windows (step STRIDE) to the PE array over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | issuing bank reads and assembling windows
// FLUSH  | all reads issued; draining last read, hold entry and output slot
module bank_window_fetch #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int STRIDE     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        length,
  output logic                         csen,
  output logic                         rdena,
  output logic [ADDR_WIDTH-1:0]        addr_a,
  input  logic [DATA_WIDTH-1:0]        data_a,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [KERNEL*DATA_WIDTH-1:0] win_data,
  output logic                         busy,
  output logic                         done
);

  localparam int WW = KERNEL * DATA_WIDTH;
  localparam int CW = $clog2(KERNEL + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_rd_pend;
  logic [WW-1:0]         r_sr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_vld;
  logic                  r_win_valid;
  logic [WW-1:0]         r_win_data;
  logic                  r_done;

  logic                  w_slot_free;
  logic                  w_issue;
  logic                  w_start_ok;
  logic                  w_start_short;
  logic                  w_flush_done;
  logic                  w_complete;
  logic                  w_park;
  logic                  w_release;
  logic                  w_shift;
  logic                  w_emit;
  logic [DATA_WIDTH-1:0] w_sr_in;
  logic [WW-1:0]         w_sr_next;

  assign w_slot_free   = !r_win_valid || win_ready;
  assign w_start_ok    = (r_state == S_IDLE) && start && (length >= ADDR_WIDTH'(KERNEL));
  assign w_start_short = (r_state == S_IDLE) && start && (length < ADDR_WIDTH'(KERNEL));
  assign w_issue       = (r_state == S_FETCH) && (r_rd_ptr < r_len) && !r_hold_vld && w_slot_free;
  assign w_flush_done  = (r_state == S_FLUSH) && !r_rd_pend && !r_hold_vld && w_slot_free;

  // A held sample and a returning read never coexist: reads stop while the slot is blocked.
  assign w_complete = r_rd_pend && (r_cnt == CW'(1));
  assign w_park     = w_complete && !w_slot_free;
  assign w_release  = r_hold_vld && w_slot_free;
  assign w_shift    = (r_rd_pend && !w_park) || w_release;
  assign w_emit     = (w_complete && w_slot_free) || w_release;
  assign w_sr_in    = r_hold_vld ? r_hold : data_a;
  assign w_sr_next  = {w_sr_in, r_sr[WW-1:DATA_WIDTH]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_FETCH;
      S_FETCH: if (r_rd_ptr == r_len) w_next = S_FLUSH;
      S_FLUSH: if (w_flush_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_rd_ptr    <= '0;
      r_rd_pend   <= 1'b0;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= w_start_short || w_flush_done;
      r_rd_pend <= w_issue;

      if (w_start_ok) begin
        r_base     <= base_addr;
        r_len      <= length;
        r_rd_ptr   <= '0;
        r_cnt      <= CW'(KERNEL);
        r_sr       <= '0;
        r_hold_vld <= 1'b0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end

      if (r_rd_pend) begin
        if (w_complete) r_cnt <= CW'(STRIDE);
        else            r_cnt <= r_cnt - CW'(1);
      end

      if (w_shift) r_sr <= w_sr_next;

      if (w_park) begin
        r_hold     <= data_a;
        r_hold_vld <= 1'b1;
      end else if (w_release) begin
        r_hold_vld <= 1'b0;
      end

      if (w_emit) begin
        r_win_data  <= w_sr_next;
        r_win_valid <= 1'b1;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign csen      = busy;
  assign rdena     = w_issue;
  assign addr_a    = w_issue ? (r_base + r_rd_ptr) : '0;
  assign win_valid = r_win_valid;
  assign win_data  = r_win_data;
  assign done      = r_done;

endmodule

// File: tb/tb_bank_window_fetch.sv
// Bench for bank_window_fetch: a STRIDE=1 and a STRIDE=2 instance share a bank model;
// expected windows are queued at job launch and popped on every accepted window.
module tb_bank_window_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start     [2];
  logic [12:0] base_addr [2];
  logic [12:0] length    [2];
  logic        csen      [2];
  logic        rdena     [2];
  logic [12:0] addr_a    [2];
  logic [7:0]  data_a    [2];
  logic        win_valid [2];
  logic        win_ready [2];
  logic [23:0] win_data  [2];
  logic        busy      [2];
  logic        done      [2];

  logic [7:0]  mem [8192];

  always #5 clk = ~clk;

  bank_window_fetch #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .KERNEL(3), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]), .length(length[0]),
    .csen(csen[0]), .rdena(rdena[0]), .addr_a(addr_a[0]), .data_a(data_a[0]),
    .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_data(win_data[0]),
    .busy(busy[0]), .done(done[0]));

  bank_window_fetch #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .KERNEL(3), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]), .length(length[1]),
    .csen(csen[1]), .rdena(rdena[1]), .addr_a(addr_a[1]), .data_a(data_a[1]),
    .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_data(win_data[1]),
    .busy(busy[1]), .done(done[1]));

  // Synchronous bank read port: one-cycle latency, zero when not enabled.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) data_a[k] <= rdena[k] ? mem[addr_a[k]] : 8'h00;
  end

  typedef struct {
    int          inst;
    logic [12:0] base;
    logic [12:0] len;
    int          bp_len;
    bit          mid_start;
    int          exp_win;
    int          exp_wv;
    int          exp_done;
  } vec_t;

  vec_t vecs [9];

  int nchk = 0;
  int npass = 0;

  int          cur;
  int          cyc;
  int          n_win;
  int          n_done;
  int          done_cyc;
  int          first_wv;
  int          rd_cnt;
  int          stall_rd;
  int          busy_seen;
  bit          stall_prev;
  logic [23:0] prev_data;
  logic [12:0] rd_addr_q [$];
  logic [23:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic clear_job();
    cyc = 0; n_win = 0; n_done = 0; done_cyc = -1; first_wv = -1;
    rd_cnt = 0; stall_rd = 0; busy_seen = 0; stall_prev = 1'b0; prev_data = '0;
    rd_addr_q.delete();
    exp_q.delete();
  endtask

  task automatic monitor();
    int k;
    logic [23:0] e;
    k = cur;
    if (busy[k]) busy_seen = 1;
    if (rdena[k]) begin
      rd_cnt++;
      rd_addr_q.push_back(addr_a[k]);
      if (win_valid[k] && !win_ready[k]) stall_rd++;
    end
    if (stall_prev) chk("win_data_stable", win_data[k], prev_data);
    stall_prev = win_valid[k] && !win_ready[k];
    prev_data  = win_data[k];
    if (win_valid[k] && first_wv < 0) first_wv = cyc;
    if (win_valid[k] && win_ready[k]) begin
      n_win++;
      if (exp_q.size() == 0) begin
        nchk++;
        $display("FAIL extra_window: got window %06h, required none", win_data[k]);
      end else begin
        e = exp_q.pop_front();
        chk("win_data", win_data[k], e);
      end
    end
    if (done[k]) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_model(input int stride, input logic [12:0] b, input logic [12:0] len);
    logic [12:0] a0, a1, a2;
    for (int i = 0; i + 3 <= int'(len); i += stride) begin
      a0 = b + 13'(i);
      a1 = a0 + 13'd1;
      a2 = a0 + 13'd2;
      exp_q.push_back({mem[a2], mem[a1], mem[a0]});
    end
  endtask

  task automatic run_job(input vec_t v);
    int          bp_cnt;
    bit          bp_on;
    int          after;
    logic [12:0] ea;
    clear_job();
    cur = v.inst;
    base_addr[cur] = v.base;
    length[cur]    = v.len;
    win_ready[cur] = 1'b1;
    start[cur]     = 1'b1;
    push_model((cur == 0) ? 1 : 2, v.base, v.len);
    tick();
    start[cur] = 1'b0;
    bp_cnt = 0; bp_on = 0; after = 0;
    for (int c = 1; c < 400 && after < 3; c++) begin
      if (v.mid_start && c == 2) begin
        start[cur] = 1'b1; base_addr[cur] = 13'h0700; length[cur] = 13'd20;
      end else begin
        start[cur] = 1'b0;
      end
      if (v.bp_len > 0 && bp_cnt < v.bp_len && (bp_on || win_valid[cur])) begin
        bp_on = 1; bp_cnt++; win_ready[cur] = 1'b0;
      end else begin
        win_ready[cur] = 1'b1;
      end
      tick();
      if (n_done > 0) after++;
    end
    start[cur] = 1'b0;
    win_ready[cur] = 1'b1;
    if (n_done == 0) begin
      nchk++;
      $display("FAIL timeout_no_done: got no done within bound, required one done pulse");
    end
    chk("window_count", n_win, v.exp_win);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_pulses", n_done, 1);
    chk("read_count", rd_cnt, (v.len >= 13'd3) ? int'(v.len) : 0);
    chk("reads_while_stalled", stall_rd, 0);
    chk("first_win_valid_cycle", first_wv, v.exp_wv);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    chk("busy_seen", busy_seen, (v.len >= 13'd3) ? 1 : 0);
    chk("busy_after", busy[cur], 0);
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      ea = v.base + 13'(i);
      chk("addr_a", rd_addr_q[i], ea);
    end
  endtask

  task automatic chk_outputs_zero(input int k);
    chk("rst_csen", csen[k], 0);
    chk("rst_rdena", rdena[k], 0);
    chk("rst_addr_a", addr_a[k], 0);
    chk("rst_win_valid", win_valid[k], 0);
    chk("rst_win_data", win_data[k], 0);
    chk("rst_busy", busy[k], 0);
    chk("rst_done", done[k], 0);
  endtask

  initial begin
    //          inst base      len  bp  mid win wv  done
    vecs[0] = '{0, 13'h0010, 13'd5, 0,  0,  3,  5,  8};
    vecs[1] = '{1, 13'h0010, 13'd6, 0,  0,  2,  5,  9};
    vecs[2] = '{0, 13'h0010, 13'd5, 10, 0,  3,  5,  19};
    vecs[3] = '{0, 13'h1FFF, 13'd3, 0,  0,  1,  5,  6};
    vecs[4] = '{0, 13'h0100, 13'd2, 0,  0,  0,  -1, 1};
    vecs[5] = '{1, 13'h0200, 13'd9, 0,  1,  4,  5,  12};
    vecs[6] = '{0, 13'h0300, 13'd8, 3,  1,  6,  5,  -1};
    vecs[7] = '{1, 13'h0000, 13'd0, 0,  0,  0,  -1, 1};
    vecs[8] = '{0, 13'h0500, 13'd4, 0,  0,  2,  5,  7};

    for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[16 + i] = 8'(i + 1);
    mem[13'h1FFF] = 8'hA1;
    mem[0]        = 8'hA2;
    mem[1]        = 8'hA3;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; base_addr[k] = '0; length[k] = '0; win_ready[k] = 1'b1;
    end
    clear_job();
    cur = 0;
    @(negedge clk);
    @(negedge clk);
    chk_outputs_zero(0);
    chk_outputs_zero(1);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_job(vecs[v]);

    // Abort a job mid-FETCH, then confirm the next job carries no stale samples.
    clear_job();
    cur = 0;
    base_addr[0] = 13'h0400; length[0] = 13'd10; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    chk("busy_before_rst", busy[0], 1);
    rst = 1'b1;
    tick();
    chk_outputs_zero(0);
    rst = 1'b0;
    tick();
    run_job(vecs[8]);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/bank_window_fetch.md
Name: bank_window_fetch

Overview:
- Read-side consumer of one feature-memory bank in the ECG accelerator.
- Streams a contiguous sample segment out of the bank's synchronous read port (1-cycle latency; read data is 0 when the read is not enabled).
- Assembles sliding windows of KERNEL samples with step STRIDE and hands them to the conv PE array over a valid/ready handshake.
- Supports PE backpressure with no sample loss and no re-reads.

Parameters:
- ADDR_WIDTH, 13, bank address width.
- DATA_WIDTH, 8, sample width.
- KERNEL, 3, window length in samples (≥2).
- STRIDE, 1, samples between consecutive window starts (1 ≤ STRIDE ≤ KERNEL).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- start  in  1  one-cycle launch pulse; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  first sample address; latched on start.
- length  in  ADDR_WIDTH  number of samples to read; latched on start.
- csen  out  1  bank chip select.
- rdena  out  1  bank read enable.
- addr_a  out  ADDR_WIDTH  bank read address.
- data_a  in  DATA_WIDTH  bank read data, valid the cycle after rdena.
- win_valid  out  1  window available.
- win_ready  in  1  PE accepts the window.
- win_data  out  KERNEL*DATA_WIDTH  window; slice 0 (LSBs) is the oldest sample, top slice is the newest.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0 (csen, rdena, addr_a, win_valid, win_data, busy, done). FSM goes to IDLE; pointers, counters and hold register are cleared. Reset mid-job aborts immediately; any in-flight read data is dropped.
- FSM states: IDLE, FETCH, FLUSH.
- IDLE:
  - start with length ≥ KERNEL: latch inputs, rd_ptr=0, busy=1, go to FETCH.
  - start with length < KERNEL: done=1 in the next cycle, stay in IDLE, never assert rdena.
- FETCH, read issue: a read is issued in a cycle iff all of the following hold:
  - rd_ptr < length,
  - hold register empty,
  - NOT (win_valid && !win_ready).
- FETCH, read signalling: rdena=1 only for issued reads. addr_a = (base_addr + rd_ptr) mod 2^ADDR_WIDTH (wraps). rd_ptr increments per issued read. csen=1 whenever busy=1.
- Returned sample (the cycle after an issued read):
  - Shifts into a KERNEL-deep shift register.
  - new_cnt counts samples since the last window. The first window completes when KERNEL samples have been received; each later window completes after STRIDE further samples.
  - If the sample completes a window and the output slot is free or being accepted that cycle: load win_data with the new window and set win_valid=1.
  - If it completes a window while win_valid && !win_ready: park the sample in the 1-entry hold register. When the slot frees, shift it in and emit the window; issue no new reads while the hold register is occupied.
  - A non-completing sample always shifts in directly.
- Output handshake:
  - win_valid && win_ready transfers the window. win_valid drops next cycle unless a new window loads the same cycle.
  - win_data is stable while win_valid && !win_ready.
- Transition to FLUSH: once rd_ptr == length, move to FLUSH.
- FLUSH: wait until the last read has returned, the hold register is empty, and win_valid=0 (or the final window is accepted). Then done=1 for one cycle, busy=0, return to IDLE.
- Trailing samples that cannot complete a window are read and discarded.
- Window count = (length − KERNEL)/STRIDE + 1 (integer division).
- Latency: start in cycle 0 → first rdena in cycle 1 → first win_valid in cycle KERNEL+2 (win_ready held 1). Afterwards one window every STRIDE cycles; sustained read rate is 1 sample/cycle without backpressure.
- start during busy: ignored, latched values unchanged.

Test Plan:
- KERNEL=3, STRIDE=1, base=0x010, length=5, mem[0x10..0x14]=1..5, win_ready=1:
  - addr_a sequence 0x10..0x14 in cycles 1..5.
  - win_data = 0x030201 in cycle 5, then 0x040302, then 0x050403.
  - done one cycle after the final window is accepted.
- STRIDE=2, length=6, data 1..6: exactly two windows, 0x030201 and 0x050403. Sample 6 is read and discarded; done follows.
- Backpressure, same setup as case 1: win_ready=0 for 10 cycles after the first win_valid.
  - win_data holds 0x030201, rdena stops after at most one further read, and one sample is held.
  - On release, windows 0x040302 and 0x050403 follow in order, none lost or duplicated.
- length=2: done pulses in cycle 1; rdena, win_valid and busy stay 0.
- Wrap: base=0x1FFF, length=3 → addr_a = 0x1FFF, 0x0000, 0x0001; one window.
- rst=1 in mid-FETCH, then start a new job: all outputs 0 the cycle after reset; the new job's windows contain no samples from the aborted job.
